// File: rtl/axis_i2c_cmd_ctrl_pkg.sv
// Shared constants for the AXIS-to-I2C command controller.
// Latency: n/a (constants and helper functions only).
// Backpressure: n/a.
package axis_i2c_cmd_ctrl_pkg;

    // Control FSM encodings
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Consecutive ready cycles after a launch that count as "FSM ignored start"
    localparam int                     GUARD_LIMIT = 2;
    localparam int                     GUARD_WIDTH = 2;
    localparam logic [GUARD_WIDTH-1:0] GUARD_LAST  = GUARD_WIDTH'(GUARD_LIMIT - 1);

    // tdata layout: {addr, data}, address sits directly above the payload
    function automatic int addr_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int tdata_width(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

endpackage

// File: rtl/axis_i2c_cmd_ctrl_fifo.sv
// Command FIFO: push/pop with full/empty/level, head read from the storage flop at rd_ptr.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module axis_i2c_cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end
endmodule

// File: rtl/axis_i2c_cmd_ctrl.sv
// AXIS slave front end: buffers {addr,data} beats and launches one I2C write per beat.
// Latency: beat accepted in cycle N reaches i2c_start in cycle N+2 (empty FIFO, idle FSM).
// Backpressure: s_axis_tready drops while the FIFO is full; no same-cycle pass-through.
module axis_i2c_cmd_ctrl
    import axis_i2c_cmd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             i2c_ready,
    output logic                             i2c_start,
    output logic [ADDR_WIDTH-1:0]            i2c_addr,
    output logic [DATA_WIDTH-1:0]            i2c_data,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic [CNT_WIDTH-1:0]             tx_count
);
    localparam int TW       = tdata_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [GUARD_WIDTH-1:0] guard;
    logic [TW-1:0]          head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   launch;
    logic                   guard_hit;
    logic                   xfer_done;

    assign s_axis_tready = arst_n && !fifo_full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign launch        = (state == ST_IDLE) && !fifo_empty && i2c_ready;
    assign guard_hit     = (state == ST_WAIT_BUSY) && i2c_ready && (guard == GUARD_LAST);
    assign xfer_done     = (state == ST_WAIT_DONE) && i2c_ready;

    // done/err are Mealy pulses so the next launch can follow two cycles after done
    assign done = arst_n && xfer_done;
    assign err  = arst_n && guard_hit;
    assign busy = (state != ST_IDLE);

    axis_i2c_cmd_fifo #(
        .WIDTH (TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .push     (push),
        .push_dat (s_axis_tdata),
        .pop      (launch),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Next-state decode for the launch/acknowledge sequence
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (launch) state_nxt = ST_LAUNCH;
            ST_LAUNCH:    state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!i2c_ready)     state_nxt = ST_WAIT_DONE;
                else if (guard_hit) state_nxt = ST_IDLE;
            end
            ST_WAIT_DONE: if (i2c_ready) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // State, registered launch outputs, guard counter and completion count
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            i2c_start <= 1'b0;
            i2c_addr  <= '0;
            i2c_data  <= '0;
            guard     <= '0;
            tx_count  <= '0;
        end else begin
            state     <= state_nxt;
            // start is high exactly while the state register holds LAUNCH
            i2c_start <= launch;
            if (launch) begin
                i2c_addr <= head[ADDR_LSB +: ADDR_WIDTH];
                i2c_data <= head[DATA_WIDTH-1:0];
            end
            if (state == ST_LAUNCH)                     guard <= '0;
            else if (state == ST_WAIT_BUSY && i2c_ready) guard <= guard + 1'b1;
            if (xfer_done) tx_count <= tx_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_i2c_cmd_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: the bench honours tready and holds tdata stable while a beat is pending.
module tb_axis_i2c_cmd_ctrl;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TW = AW + DW;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [TW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          i2c_ready = 1'b1;
    logic          i2c_start;
    logic [AW-1:0] i2c_addr;
    logic [DW-1:0] i2c_data;
    logic          busy, done, err;
    logic [2:0]    fifo_level;
    logic [15:0]   tx_count;

    logic          tready_w2, start_w2, busy_w2, done_w2, err_w2;
    logic [AW-1:0] addr_w2;
    logic [DW-1:0] data_w2;
    logic [2:0]    level_w2;
    logic [1:0]    tx_count_w2;

    always #5 clk = ~clk;

    axis_i2c_cmd_ctrl dut (
        .clk(clk), .arst_n(arst_n), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .i2c_ready(i2c_ready), .i2c_start(i2c_start),
        .i2c_addr(i2c_addr), .i2c_data(i2c_data), .busy(busy), .done(done), .err(err),
        .fifo_level(fifo_level), .tx_count(tx_count)
    );

    axis_i2c_cmd_ctrl #(.CNT_WIDTH(2)) dut_w2 (
        .clk(clk), .arst_n(arst_n), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(tready_w2), .i2c_ready(i2c_ready), .i2c_start(start_w2),
        .i2c_addr(addr_w2), .i2c_data(data_w2), .busy(busy_w2), .done(done_w2), .err(err_w2),
        .fifo_level(level_w2), .tx_count(tx_count_w2)
    );

    // Downstream I2C FSM model. mode 0: normal (busy lat+1 cycles after start),
    // mode 1: ignores start (ready stays high), mode 2: held busy (ready low).
    int mode = 0;
    int lat  = 2;
    int m_cnt = 0;
    bit m_busy = 1'b0;

    always @(posedge clk) begin
        if (mode == 2) begin
            i2c_ready <= 1'b0;
            m_busy    <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                i2c_ready <= 1'b1;
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (i2c_start === 1'b1 && mode == 0) begin
            i2c_ready <= 1'b0;
            m_busy    <= 1'b1;
            m_cnt     <= lat;
        end else begin
            i2c_ready <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_on = 1'b0;
    logic [TW-1:0] exp_q [$];
    int model_cnt = 0;
    int n_start = 0, n_done = 0, n_err = 0;
    int last_start = -100, last_done = -100, last_err = -100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: capture handshake, advance, then score the new cycle
    task automatic step();
        bit acc, rst;
        logic [TW-1:0] d, h;
        acc = (s_axis_tvalid === 1'b1) && (s_axis_tready === 1'b1);
        rst = (arst_n === 1'b0);
        d   = s_axis_tdata;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_on) begin
            if (rst) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                if (acc) exp_q.push_back(d);
                if (i2c_start === 1'b1) begin
                    n_start++;
                    chk("launch_has_cmd", 32'(exp_q.size() > 0), 1);
                    chk("b2b_gap", 32'((cyc - last_done) >= 2), 1);
                    if (exp_q.size() > 0) begin
                        h = exp_q.pop_front();
                        chk("launch_addr", 32'(i2c_addr), 32'(h[TW-1:DW]));
                        chk("launch_data", 32'(i2c_data), 32'(h[DW-1:0]));
                        chk("launch_addr_w2", 32'(addr_w2), 32'(h[TW-1:DW]));
                        chk("launch_data_w2", 32'(data_w2), 32'(h[DW-1:0]));
                    end
                    last_start = cyc;
                end
            end
            chk("tx_count", 32'(tx_count), model_cnt % 65536);
            chk("tx_count_w2", 32'(tx_count_w2), model_cnt % 4);
            chk("fifo_level", 32'(fifo_level), exp_q.size());
            chk("fifo_level_w2", 32'(level_w2), exp_q.size());
            chk("tready", 32'(s_axis_tready), 32'((arst_n === 1'b1) && (exp_q.size() < DEPTH)));
            chk("tready_w2", 32'(tready_w2), 32'((arst_n === 1'b1) && (exp_q.size() < DEPTH)));
            chk("w2_lockstep", 32'({start_w2, done_w2, err_w2, busy_w2}),
                32'({i2c_start, done, err, busy}));
            if (!rst && done === 1'b1) begin model_cnt++; n_done++; last_done = cyc; end
            if (!rst && err === 1'b1)  begin n_err++; last_err = cyc; end
        end
    endtask

    function automatic int ev_count(input int which);
        if (which == 0) return n_start;
        if (which == 1) return n_done;
        return n_err;
    endfunction

    task automatic wait_ev(input int which, input int target, input int budget, input string tag);
        int k = 0;
        while (k < budget && ev_count(which) < target) begin
            step();
            k++;
        end
        chk(tag, 32'(ev_count(which) >= target), 1);
    endtask

    // Offer a beat until accepted; leaves tvalid asserted for back-to-back use
    task automatic push_beat(input logic [TW-1:0] d, input int budget, output bit ok);
        bit a;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        for (int k = 0; k < budget && !ok; k++) begin
            a = (s_axis_tready === 1'b1);
            step();
            ok = a;
        end
    endtask

    initial begin
        int acc_cyc, s0, d0, e0, tc0, sent;
        bit ok, a;
        logic [TW-1:0] beats [5];
        int exp_seq [5] = '{1, 2, 3, 0, 1};

        // 1. reset with tvalid high
        arst_n = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = TW'($urandom);
        repeat (3) step();
        auto_on = 1'b1;
        step();
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_start", 32'(i2c_start), 0);
        chk("rst_addr", 32'(i2c_addr), 0);
        chk("rst_data", 32'(i2c_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_tx", 32'(tx_count), 0);
        arst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("rel_tready", 32'(s_axis_tready), 1);
        chk("rel_level", 32'(fifo_level), 0);

        // 2. single beat latency and completion
        mode = 0; lat = 3;
        s0 = n_start; d0 = n_done;
        s_axis_tdata = {7'h50, 8'hA5};
        s_axis_tvalid = 1'b1;
        acc_cyc = cyc;
        step();
        s_axis_tvalid = 1'b0;
        chk("t2_level", 32'(fifo_level), 1);
        wait_ev(0, s0 + 1, 10, "t2_start_seen");
        chk("t2_latency", last_start - acc_cyc, 2);
        chk("t2_addr", 32'(i2c_addr), 32'h50);
        chk("t2_data", 32'(i2c_data), 32'hA5);
        wait_ev(1, d0 + 1, 20, "t2_done_seen");
        chk("t2_addr_stable", 32'(i2c_addr), 32'h50);
        chk("t2_busy_in_done", 32'(busy), 1);
        step();
        chk("t2_tx", 32'(tx_count), 1);
        chk("t2_idle", 32'(busy), 0);

        // 3. fill FIFO while downstream is held busy
        mode = 2;
        step(); step();
        s0 = n_start; d0 = n_done; tc0 = model_cnt;
        for (int i = 0; i < 5; i++) beats[i] = TW'($urandom);
        for (int i = 0; i < 4; i++) begin
            push_beat(beats[i], 5, ok);
            chk("t3_accept", 32'(ok), 1);
        end
        s_axis_tdata = beats[4];
        chk("t3_tready_low", 32'(s_axis_tready), 0);
        repeat (3) step();
        chk("t3_level_full", 32'(fifo_level), 4);
        chk("t3_no_launch", n_start - s0, 0);
        mode = 0; lat = 1;
        push_beat(beats[4], 40, ok);
        s_axis_tvalid = 1'b0;
        chk("t3_fifth_accept", 32'(ok), 1);
        wait_ev(1, d0 + 5, 200, "t3_all_done");
        chk("t3_starts", n_start - s0, 5);
        chk("t3_tx_delta", model_cnt - tc0, 5);

        // 4. downstream ignores start
        mode = 1;
        step(); step();
        s0 = n_start; d0 = n_done; e0 = n_err; tc0 = model_cnt;
        push_beat(TW'($urandom), 5, ok);
        push_beat(TW'($urandom), 5, ok);
        s_axis_tvalid = 1'b0;
        wait_ev(0, s0 + 1, 10, "t4_start_seen");
        wait_ev(2, e0 + 1, 10, "t4_err_seen");
        chk("t4_err_delay", last_err - last_start, 2);
        mode = 0; lat = 2;
        chk("t4_tx_same", 32'(tx_count), 32'(tc0));
        wait_ev(0, s0 + 2, 10, "t4_next_start");
        wait_ev(1, d0 + 1, 20, "t4_next_done");
        chk("t4_err_count", n_err - e0, 1);
        chk("t4_done_count", n_done - d0, 1);

        // 5. reset during WAIT_DONE with two entries buffered
        lat = 30;
        step(); step();
        s0 = n_start;
        for (int i = 0; i < 3; i++) push_beat(TW'($urandom), 5, ok);
        s_axis_tvalid = 1'b0;
        wait_ev(0, s0 + 1, 10, "t5_start_seen");
        repeat (3) step();
        chk("t5_busy_pre", 32'(busy), 1);
        chk("t5_level_pre", 32'(fifo_level), 2);
        arst_n = 1'b0;
        step();
        chk("t5_level_rst", 32'(fifo_level), 0);
        chk("t5_busy_rst", 32'(busy), 0);
        arst_n = 1'b1;
        s0 = n_start; d0 = n_done;
        repeat (40) step();
        chk("t5_no_replay", n_start - s0, 0);
        chk("t5_no_done", n_done - d0, 0);

        // 6. narrow counter wraps: 1,2,3,0,1
        for (int t = 0; t < 5; t++) begin
            lat = $urandom_range(0, 3);
            d0 = n_done;
            push_beat(TW'($urandom), 5, ok);
            s_axis_tvalid = 1'b0;
            wait_ev(1, d0 + 1, 50, "t6_done_seen");
            step();
            chk("t6_wrap_seq", 32'(tx_count_w2), exp_seq[t]);
        end

        // 7. random traffic with random downstream latency
        d0 = n_done;
        sent = 0;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = (s_axis_tvalid === 1'b1) && (s_axis_tready === 1'b1);
            lat = $urandom_range(0, 4);
            step();
            if (a) sent++;
            if (a || s_axis_tvalid === 1'b0) begin
                s_axis_tvalid = (sent < 40) && ($urandom_range(0, 2) != 0);
                s_axis_tdata  = TW'($urandom);
            end
        end
        s_axis_tvalid = 1'b0;
        wait_ev(1, d0 + sent, 2000, "t7_drain");
        chk("t7_done_count", n_done - d0, sent);
        chk("t7_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
